// File: rtl/game_flow_ctrl.sv
// Multi-level, multi-life game sequencer: start, stage load, run, pause, hit/respawn, over, won.
// Optional score counter enabled by defining GAME_FLOW_SCORE_EN (otherwise score is tied to 0).
module game_flow_ctrl #(
  parameter int unsigned LIVES          = 3,
  parameter int unsigned LEVELS         = 4,
  parameter int unsigned RESPAWN_CYCLES = 50000000,
  parameter int unsigned SCORE_W        = 16,
  localparam int unsigned LVL_W = (LEVELS > 1) ? $clog2(LEVELS) : 1,
  localparam int unsigned LIV_W = $clog2(LIVES + 1),
  localparam int unsigned CNT_W = (RESPAWN_CYCLES > 1) ? $clog2(RESPAWN_CYCLES) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               key_start,
  input  logic               key_pause,
  input  logic               collision_detected,
  input  logic               stage_cleared,
  output logic               run_game,
  output logic               stage_load,
  output logic [LVL_W-1:0]   level,
  output logic [LIV_W-1:0]   lives_left,
  output logic               game_over,
  output logic               game_won,
  output logic               led_red,
  output logic               led_green,
  output logic [SCORE_W-1:0] score
);

  localparam logic [LIV_W-1:0] LivesInit = LIV_W'(LIVES);
  localparam logic [LVL_W-1:0] LevelLast = LVL_W'(LEVELS - 1);
  localparam logic [CNT_W-1:0] CntLast   = CNT_W'(RESPAWN_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StRunning,
    StPaused,
    StHit,
    StOver,
    StWon
  } state_e;

  state_e             r_state;
  logic [LVL_W-1:0]   r_level;
  logic [LIV_W-1:0]   r_lives;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_key_start_q;
  logic               r_key_pause_q;
  logic               r_run;
  logic               r_load;
  logic               r_over;
  logic               r_won;
  logic               r_red;
  logic               r_green;

  state_e             w_state_d;
  logic [LVL_W-1:0]   w_level_d;
  logic [LIV_W-1:0]   w_lives_d;
  logic [CNT_W-1:0]   w_cnt_d;
  logic               w_start_edge;
  logic               w_pause_edge;

  assign w_start_edge = key_start & ~r_key_start_q;
  assign w_pause_edge = key_pause & ~r_key_pause_q;

  always_comb begin
    w_state_d = r_state;
    w_level_d = r_level;
    w_lives_d = r_lives;
    w_cnt_d   = r_cnt;
    case (r_state)
      StIdle: begin
        if (w_start_edge) begin
          w_state_d = StLoad;
          w_level_d = '0;
          w_lives_d = LivesInit;
        end
      end
      StLoad: begin
        w_state_d = StRunning;
      end
      StRunning: begin
        // Collision outranks stage clear, which outranks pause.
        if (collision_detected) begin
          w_state_d = StHit;
          w_cnt_d   = '0;
          if (r_lives != '0) begin
            w_lives_d = r_lives - LIV_W'(1);
          end
        end else if (stage_cleared) begin
          if (r_level == LevelLast) begin
            w_state_d = StWon;
          end else begin
            w_level_d = r_level + LVL_W'(1);
            w_state_d = StLoad;
          end
        end else if (w_pause_edge) begin
          w_state_d = StPaused;
        end
      end
      StPaused: begin
        if (w_start_edge) begin
          w_state_d = StIdle;
        end else if (w_pause_edge) begin
          w_state_d = StRunning;
        end
      end
      StHit: begin
        if (r_lives == '0) begin
          w_state_d = StOver;
        end else if (r_cnt == CntLast) begin
          w_state_d = StLoad;
          w_cnt_d   = '0;
        end else begin
          w_cnt_d = r_cnt + CNT_W'(1);
        end
      end
      StOver, StWon: begin
        if (w_start_edge) begin
          w_state_d = StIdle;
        end
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  // Outputs are decoded from the next state so they flip together with the state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= StIdle;
      r_level       <= '0;
      r_lives       <= LivesInit;
      r_cnt         <= '0;
      r_key_start_q <= 1'b1;
      r_key_pause_q <= 1'b1;
      r_run         <= 1'b0;
      r_load        <= 1'b0;
      r_over        <= 1'b0;
      r_won         <= 1'b0;
      r_red         <= 1'b0;
      r_green       <= 1'b1;
    end else begin
      r_state       <= w_state_d;
      r_level       <= w_level_d;
      r_lives       <= w_lives_d;
      r_cnt         <= w_cnt_d;
      r_key_start_q <= key_start;
      r_key_pause_q <= key_pause;
      r_run         <= (w_state_d == StRunning);
      r_load        <= (w_state_d == StLoad);
      r_over        <= (w_state_d == StOver);
      r_won         <= (w_state_d == StWon);
      r_red         <= (w_state_d == StHit) || (w_state_d == StOver) ||
                       (w_state_d == StPaused);
      r_green       <= (w_state_d == StIdle) || (w_state_d == StLoad) ||
                       (w_state_d == StRunning) || (w_state_d == StWon) ||
                       (w_state_d == StPaused);
    end
  end

  assign run_game   = r_run;
  assign stage_load = r_load;
  assign level      = r_level;
  assign lives_left = r_lives;
  assign game_over  = r_over;
  assign game_won   = r_won;
  assign led_red    = r_red;
  assign led_green  = r_green;

`ifdef GAME_FLOW_SCORE_EN
  localparam int unsigned SUM_W = SCORE_W + 8;
  localparam logic [SUM_W-1:0] ScoreMax = SUM_W'({SCORE_W{1'b1}});

  logic [19:0]        r_div;
  logic [SCORE_W-1:0] r_score;
  logic [SCORE_W-1:0] w_score_d;
  logic [SUM_W-1:0]   w_sum;

  always_comb begin
    w_score_d = r_score;
    w_sum     = '0;
    if ((r_state == StIdle) && w_start_edge) begin
      w_score_d = '0;
    end else if (r_state == StRunning) begin
      // An accepted stage clear awards its bonus in place of the tick increment.
      if (!collision_detected && stage_cleared) begin
        w_sum = SUM_W'(r_score) + SUM_W'(100);
      end else if (r_div == '1) begin
        w_sum = SUM_W'(r_score) + SUM_W'(1);
      end else begin
        w_sum = SUM_W'(r_score);
      end
      w_score_d = (w_sum > ScoreMax) ? SCORE_W'(ScoreMax) : SCORE_W'(w_sum);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_div   <= '0;
      r_score <= '0;
    end else begin
      r_score <= w_score_d;
      if (r_state == StRunning) begin
        r_div <= r_div + 20'd1;
      end
    end
  end

  assign score = r_score;
`else
  assign score = '0;
`endif

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Self-checking bench for game_flow_ctrl: directed scenarios plus random traffic vs a behavioural model.
module tb_game_flow_ctrl;

  localparam int LIVES  = 3;
  localparam int LEVELS = 2;
  localparam int RESP   = 4;

  localparam int P_IDLE  = 0;
  localparam int P_LOAD  = 1;
  localparam int P_RUN   = 2;
  localparam int P_PAUSE = 3;
  localparam int P_HIT   = 4;
  localparam int P_OVER  = 5;
  localparam int P_WON   = 6;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        key_start = 1'b0;
  logic        key_pause = 1'b0;
  logic        collision_detected = 1'b0;
  logic        stage_cleared = 1'b0;
  logic        run_game;
  logic        stage_load;
  logic [0:0]  level;
  logic [1:0]  lives_left;
  logic        game_over;
  logic        game_won;
  logic        led_red;
  logic        led_green;
  logic [15:0] score;

  int n_err = 0;
  int n_chk = 0;

  // Model of the game: phase, stage, lives, cycles already spent in the hit phase.
  int m_ph    = P_IDLE;
  int m_level = 0;
  int m_lives = LIVES;
  int m_wait  = 0;
  bit m_ks    = 1'b1;
  bit m_kp    = 1'b1;

  game_flow_ctrl #(
    .LIVES          (LIVES),
    .LEVELS         (LEVELS),
    .RESPAWN_CYCLES (RESP),
    .SCORE_W        (16)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .key_start          (key_start),
    .key_pause          (key_pause),
    .collision_detected (collision_detected),
    .stage_cleared      (stage_cleared),
    .run_game           (run_game),
    .stage_load         (stage_load),
    .level              (level),
    .lives_left         (lives_left),
    .game_over          (game_over),
    .game_won           (game_won),
    .led_red            (led_red),
    .led_green          (led_green),
    .score              (score)
  );

  always #5 clk = ~clk;

  wire [24:0] w_obs = {run_game, stage_load, game_over, game_won, led_red, led_green,
                       level, lives_left, score};

  task automatic model_step();
    bit se;
    bit pe;
    if (rst) begin
      m_ph = P_IDLE; m_level = 0; m_lives = LIVES; m_wait = 0; m_ks = 1'b1; m_kp = 1'b1;
      return;
    end
    se = key_start && !m_ks;
    pe = key_pause && !m_kp;
    m_ks = key_start;
    m_kp = key_pause;
    case (m_ph)
      P_IDLE: if (se) begin m_ph = P_LOAD; m_level = 0; m_lives = LIVES; end
      P_LOAD: m_ph = P_RUN;
      P_RUN: begin
        if (collision_detected) begin
          if (m_lives > 0) m_lives = m_lives - 1;
          m_wait = 0;
          m_ph = P_HIT;
        end else if (stage_cleared) begin
          if (m_level == LEVELS - 1) m_ph = P_WON;
          else begin m_level = m_level + 1; m_ph = P_LOAD; end
        end else if (pe) begin
          m_ph = P_PAUSE;
        end
      end
      P_PAUSE: begin
        if (se) m_ph = P_IDLE;
        else if (pe) m_ph = P_RUN;
      end
      P_HIT: begin
        if (m_lives == 0) m_ph = P_OVER;
        else begin
          m_wait = m_wait + 1;
          if (m_wait >= RESP) m_ph = P_LOAD;
        end
      end
      default: if (se) m_ph = P_IDLE;
    endcase
  endtask

  function automatic logic [24:0] exp_vec();
    logic [31:0] lv;
    logic [31:0] li;
    lv = m_level;
    li = m_lives;
    return {m_ph == P_RUN, m_ph == P_LOAD, m_ph == P_OVER, m_ph == P_WON,
            (m_ph == P_HIT) || (m_ph == P_OVER) || (m_ph == P_PAUSE),
            (m_ph == P_IDLE) || (m_ph == P_LOAD) || (m_ph == P_RUN) || (m_ph == P_WON) ||
            (m_ph == P_PAUSE),
            lv[0], li[1:0], 16'd0};
  endfunction

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic press_start();
    key_start = 1'b1;
    tick();
    key_start = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; key_start = 1'b1; key_pause = 1'b1;
    repeat (2) tick();
    n_chk++;
    if (w_obs !== exp_vec()) begin
      n_err++; $display("FAIL reset_state: got %h want %h", w_obs, exp_vec());
    end
    n_chk++;
    if (led_green !== 1'b1 || run_game !== 1'b0 || lives_left !== 2'd3) begin
      n_err++; $display("FAIL reset_outputs: green=%b run=%b lives=%0d want 1 0 3",
                        led_green, run_game, lives_left);
    end
    rst = 1'b0;
    repeat (3) begin
      tick();
      n_chk++;
      if (w_obs !== exp_vec() || run_game !== 1'b0) begin
        n_err++; $display("FAIL held_start_idle: got %h want %h", w_obs, exp_vec());
      end
    end
    key_start = 1'b0; key_pause = 1'b0;
    tick();
    key_start = 1'b1;
    tick();
    n_chk++;
    if (w_obs !== exp_vec() || stage_load !== 1'b1) begin
      n_err++; $display("FAIL start_load: got %h want %h", w_obs, exp_vec());
    end
    key_start = 1'b0;
    tick();
    n_chk++;
    if (w_obs !== exp_vec() || run_game !== 1'b1 || stage_load !== 1'b0) begin
      n_err++; $display("FAIL start_run: got %h want %h", w_obs, exp_vec());
    end
  endtask

  task automatic test_stage_clear();
    stage_cleared = 1'b1;
    tick();
    stage_cleared = 1'b0;
    n_chk++;
    if (w_obs !== exp_vec() || level !== 1'b1 || stage_load !== 1'b1) begin
      n_err++; $display("FAIL clear_lvl0: got %h want %h", w_obs, exp_vec());
    end
    tick();
    n_chk++;
    if (w_obs !== exp_vec() || run_game !== 1'b1) begin
      n_err++; $display("FAIL clear_reload: got %h want %h", w_obs, exp_vec());
    end
    stage_cleared = 1'b1;
    tick();
    stage_cleared = 1'b0;
    n_chk++;
    if (w_obs !== exp_vec() || game_won !== 1'b1 || run_game !== 1'b0) begin
      n_err++; $display("FAIL clear_won: got %h want %h", w_obs, exp_vec());
    end
  endtask

  task automatic test_collision_respawn();
    int n;
    press_start();
    press_start();
    n_chk++;
    if (w_obs !== exp_vec() || run_game !== 1'b1) begin
      n_err++; $display("FAIL restart_run: got %h want %h", w_obs, exp_vec());
    end
    collision_detected = 1'b1; stage_cleared = 1'b1;
    tick();
    collision_detected = 1'b0; stage_cleared = 1'b0;
    n_chk++;
    if (w_obs !== exp_vec() || lives_left !== 2'd2 || level !== 1'b0 || led_red !== 1'b1) begin
      n_err++; $display("FAIL hit_entry: got %h want %h", w_obs, exp_vec());
    end
    n = 0;
    while (stage_load !== 1'b1 && n < 20) begin
      tick();
      n++;
      n_chk++;
      if (w_obs !== exp_vec()) begin
        n_err++; $display("FAIL respawn_cycle%0d: got %h want %h", n, w_obs, exp_vec());
      end
    end
    n_chk++;
    if (n !== RESP) begin
      n_err++; $display("FAIL respawn_latency: got %0d cycles want %0d", n, RESP);
    end
    tick();
    n_chk++;
    if (w_obs !== exp_vec() || run_game !== 1'b1) begin
      n_err++; $display("FAIL respawn_run: got %h want %h", w_obs, exp_vec());
    end
  endtask

  task automatic test_game_over();
    collision_detected = 1'b1;
    tick();
    collision_detected = 1'b0;
    repeat (RESP + 1) begin
      tick();
      n_chk++;
      if (w_obs !== exp_vec()) begin
        n_err++; $display("FAIL second_respawn: got %h want %h", w_obs, exp_vec());
      end
    end
    collision_detected = 1'b1;
    tick();
    collision_detected = 1'b0;
    tick();
    n_chk++;
    if (w_obs !== exp_vec() || game_over !== 1'b1 || led_red !== 1'b1 ||
        lives_left !== 2'd0) begin
      n_err++; $display("FAIL game_over: got %h want %h", w_obs, exp_vec());
    end
    press_start();
    n_chk++;
    if (w_obs !== exp_vec() || game_over !== 1'b0 || led_green !== 1'b1) begin
      n_err++; $display("FAIL over_to_idle: got %h want %h", w_obs, exp_vec());
    end
    press_start();
    n_chk++;
    if (w_obs !== exp_vec() || lives_left !== 2'd3 || level !== 1'b0) begin
      n_err++; $display("FAIL new_game: got %h want %h", w_obs, exp_vec());
    end
  endtask

  task automatic test_pause();
    key_pause = 1'b1;
    tick();
    n_chk++;
    if (w_obs !== exp_vec() || run_game !== 1'b0 || led_red !== 1'b1 || led_green !== 1'b1) begin
      n_err++; $display("FAIL pause_enter: got %h want %h", w_obs, exp_vec());
    end
    key_pause = 1'b0; collision_detected = 1'b1;
    tick();
    collision_detected = 1'b0;
    tick();
    n_chk++;
    if (w_obs !== exp_vec() || lives_left !== 2'd3) begin
      n_err++; $display("FAIL pause_ignores_hit: got %h want %h", w_obs, exp_vec());
    end
    key_pause = 1'b1;
    tick();
    n_chk++;
    if (w_obs !== exp_vec() || run_game !== 1'b1) begin
      n_err++; $display("FAIL pause_resume: got %h want %h", w_obs, exp_vec());
    end
    key_pause = 1'b0;
    tick();
    key_pause = 1'b1;
    tick();
    key_pause = 1'b0; key_start = 1'b1;
    tick();
    key_start = 1'b0;
    n_chk++;
    if (w_obs !== exp_vec() || led_red !== 1'b0 || run_game !== 1'b0) begin
      n_err++; $display("FAIL pause_abort: got %h want %h", w_obs, exp_vec());
    end
  endtask

  task automatic test_reset_in_hit();
    tick();
    press_start();
    collision_detected = 1'b1;
    tick();
    collision_detected = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_chk++;
    if (w_obs !== exp_vec() || lives_left !== 2'd3 || led_red !== 1'b0) begin
      n_err++; $display("FAIL reset_in_hit: got %h want %h", w_obs, exp_vec());
    end
    repeat (8) begin
      tick();
      n_chk++;
      if (w_obs !== exp_vec() || stage_load !== 1'b0) begin
        n_err++; $display("FAIL no_load_after_rst: got %h want %h", w_obs, exp_vec());
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 5) == 0) key_start = ~key_start;
      if ($urandom_range(0, 5) == 0) key_pause = ~key_pause;
      collision_detected = ($urandom_range(0, 11) == 0);
      stage_cleared = ($urandom_range(0, 9) == 0);
      tick();
      n_chk++;
      if (w_obs !== exp_vec()) begin
        n_err++; $display("FAIL random_cycle%0d: got %h want %h", i, w_obs, exp_vec());
      end
    end
    rst = 1'b0; collision_detected = 1'b0; stage_cleared = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stage_clear();
    test_collision_respawn();
    test_game_over();
    test_pause();
    test_reset_in_hit();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
